// File: rtl/uart_msg_loader.sv
// UART 8N1 receiver that assembles a line-terminated message and commits it atomically.
// Optional feature: define MSG_UPPERCASE_EN to fold lowercase ASCII to uppercase before storage.
module uart_msg_loader #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int MSG_LEN    = 11,
  parameter int CHAR_WIDTH = 8
) (
  input  logic                               clk_50mhz,
  input  logic                               reset_n,
  input  logic                               uart_rx,
  output logic [MSG_LEN*CHAR_WIDTH-1:0]      msg_chars,
  output logic [$clog2(MSG_LEN+1)-1:0]       msg_len,
  output logic                               msg_update,
  output logic                               frame_err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(MSG_LEN + 1);
  localparam logic [CW-1:0]         HALF  = CW'(DIV / 2);
  localparam logic [CW-1:0]         LAST  = CW'(DIV - 1);
  localparam logic [PW-1:0]         FULL  = PW'(MSG_LEN);
  localparam logic [CHAR_WIDTH-1:0] SPACE = CHAR_WIDTH'(8'h20);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      rx_shift, shift_nxt;
  logic            rx_meta, rx_sync, rx_prev;
  logic            byte_done, stop_bad;
  logic            is_term, is_bs;
  logic [CHAR_WIDTH-1:0] store_char;
  logic [PW-1:0]   wr_ptr;
  logic [CHAR_WIDTH-1:0] shadow [MSG_LEN];

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      rx_shift <= shift_nxt;
    end
  end

  // Data bits are sampled DIV cycles apart starting from the mid-start sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = rx_shift;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_sync, rx_shift[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_sync) byte_done = 1'b1;
          else         stop_bad  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    is_term    = (rx_shift == 8'h0D) || (rx_shift == 8'h0A);
    is_bs      = (rx_shift == 8'h08);
    store_char = CHAR_WIDTH'(rx_shift);
`ifdef MSG_UPPERCASE_EN
    if (rx_shift >= 8'h61 && rx_shift <= 8'h7A) store_char = CHAR_WIDTH'(rx_shift - 8'h20);
`endif
  end

  // Committed outputs only change on a terminator, so the consumer never sees a partial line.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      msg_chars  <= {MSG_LEN{SPACE}};
      msg_len    <= '0;
      msg_update <= 1'b0;
      frame_err  <= 1'b0;
      wr_ptr     <= '0;
      for (int i = 0; i < MSG_LEN; i++) shadow[i] <= SPACE;
    end else begin
      msg_update <= 1'b0;
      frame_err  <= stop_bad;
      if (byte_done) begin
        if (is_term) begin
          if (wr_ptr != '0) begin
            for (int i = 0; i < MSG_LEN; i++)
              msg_chars[i*CHAR_WIDTH +: CHAR_WIDTH] <= (PW'(i) < wr_ptr) ? shadow[i] : SPACE;
            msg_len    <= wr_ptr;
            msg_update <= 1'b1;
            wr_ptr     <= '0;
          end
        end else if (is_bs) begin
          if (wr_ptr != '0) wr_ptr <= wr_ptr - PW'(1);
        end else if (wr_ptr < FULL) begin
          shadow[wr_ptr] <= store_char;
          wr_ptr         <= wr_ptr + PW'(1);
        end
      end
    end
  end

endmodule

// File: doc/uart_msg_loader.md
# uart_msg_loader

Receives a message over a UART line (8N1) and assembles it into the character buffer that the scrolling stage displays. It sits directly upstream of the message scroller and replaces a fixed, compiled-in message. A message is committed atomically on a line terminator, so the scroller never sees a half-written message.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz
- `BAUD`, 115_200, UART bit rate
- `MSG_LEN`, 11, message buffer capacity in characters
- `CHAR_WIDTH`, 8, bits per character (ASCII)

- `clk_50mhz`  in  1  system clock. This is the only clock.
- `reset_n`  in  1  reset. Asynchronous, active-low.
- `uart_rx`  in  1  serial input. Asynchronous to the clock; idles high.
- `msg_chars`  out  MSG_LEN*CHAR_WIDTH  committed message. Character i is at bits [i*CHAR_WIDTH +: CHAR_WIDTH]; i=0 is the first character received.
- `msg_len`  out  $clog2(MSG_LEN+1)  number of valid characters in `msg_chars`.
- `msg_update`  out  1  one-cycle pulse when a new message is committed.
- `frame_err`  out  1  one-cycle pulse when a received byte has a bad stop bit.

## Operation
- **Input synchronizer:** `uart_rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Bit period:** DIV = CLK_HZ/BAUD, integer truncated (434 at the default values). The baud counter is wide enough to hold DIV-1.
- **Receiver FSM states:** IDLE, START, DATA, STOP.
  - IDLE: a high-to-low transition of the synchronized input moves the FSM to START and clears the counter.
  - START: at count DIV/2, sample the line. If low, go to DATA with the counter cleared. If high, treat it as a glitch and return to IDLE.
  - DATA: sample every DIV cycles, measured from the mid-start point. Receive 8 bits, LSB first, then go to STOP.
  - STOP: after DIV cycles, sample the line. A high sample means the byte is accepted. A low sample pulses `frame_err`, drops the byte, and returns to IDLE.
- **Shadow buffer:** accepted bytes go into a shadow buffer with write pointer `wr_ptr` (0..MSG_LEN).
  - 0x0D or 0x0A when `wr_ptr` > 0: commit. `msg_chars` receives the shadow entries [0..wr_ptr-1], and all higher positions are filled with 0x20. `msg_len` = `wr_ptr`. `msg_update` pulses and `wr_ptr` returns to 0.
  - 0x0D or 0x0A when `wr_ptr` = 0: ignored. This means CR+LF produces a single commit.
  - 0x08 (backspace): `wr_ptr` decrements if it is > 0; otherwise the byte is ignored.
  - Any other byte: if `wr_ptr` < MSG_LEN, store it at `wr_ptr` and increment. If the buffer is full, drop the byte silently; later characters are dropped until a terminator arrives.
- **Reset values:**
  - `msg_chars`: all 0x20.
  - `msg_len`: 0.
  - `msg_update`, `frame_err`: 0.
  - FSM: IDLE. `wr_ptr`: 0. Shadow buffer: 0x20.
- **Reset mid-byte:** the partial byte and the uncommitted shadow content are discarded. `msg_chars` returns to all spaces.

## Timing
- **Input to FSM:** a line edge reaches FSM decision logic 2 cycles after it arrives (synchronizer latency).
- **Commit latency:** `msg_chars`, `msg_len` and `msg_update` all update on the cycle after the terminator's stop-bit sample. They change on the same edge.
- **Back-to-back frames:** a new start bit may begin immediately after the stop bit. Byte processing completes in 1 cycle, well inside the half-bit margin.
- **frame_err timing:** asserted on the cycle after the failing stop sample, for exactly 1 cycle.
- **No handshake with the consumer:** `msg_chars` holds its value until the next commit. The consumer may sample `msg_update` to restart scrolling.

## Configuration
- `MSG_UPPERCASE_EN`
  - Defined: bytes 0x61–0x7A are converted to 0x41–0x5A before storage, to suit seven-segment glyphs.
  - Undefined: bytes are stored unmodified.
  - Terminator and backspace handling are identical either way.

## Test plan
- Send "HELLO\r" at 115200 baud. Required: one `msg_update` pulse; `msg_chars` = "HELLO" followed by 6×0x20; `msg_len` = 5.
- Send "AB\r\n". Required: exactly one `msg_update`; `msg_len` = 2; the LF produces no second pulse.
- Send 13 characters "ABCDEFGHIJKLM" then "\r". Required: `msg_chars` = "ABCDEFGHIJK"; `msg_len` = 11; "L" and "M" are dropped.
- Send "ABX", backspace, "C\r". Required: `msg_chars` begins "ABC"; `msg_len` = 3.
- Send byte 0x41 with the stop bit forced low, then "Z\r". Required: one `frame_err` pulse; the 0x41 is not stored; the result is "Z" with `msg_len` = 1.
- Assert `reset_n` low during the 4th data bit of the second character of "HI\r", release it, then send "OK\r". Required: all outputs are at reset values while reset is asserted; the final result is "OK" with `msg_len` = 2.
- With `MSG_UPPERCASE_EN` defined, send "hi\r". Required: `msg_chars` begins 0x48 0x49.
